// File: rtl/regex_match_collector_pkg.sv
// -----------------------------------------------------------------------------
// regex_collect_pkg
// Shared types and default widths for the regex match collector.
//   match_rec_t : one queued match record {idx, sig} at the default widths.
//                 It is the default record type of regex_rec_fifo; the top
//                 level builds its own record type from its parameters.
// -----------------------------------------------------------------------------
package regex_collect_pkg;

  localparam int SIG_W_DEF = 32;
  localparam int IDX_W_DEF = 16;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef struct packed {
    logic [IDX_W_DEF-1:0] idx;
    logic [SIG_W_DEF-1:0] sig;
  } match_rec_t;

endpackage

// File: rtl/regex_match_collector_fifo.sv
// -----------------------------------------------------------------------------
// regex_rec_fifo
// Registered first-word fall-through FIFO of match records.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (pointers only)
//   push_i     : write din_i. Accepted when not full, or when full and
//                popping in the same cycle.
//   din_i      : record to write
//   pop_i      : consume the head; ignored while empty
//   dout_o     : head record, forced to zero while empty
//   full_o     : occupancy equals DEPTH
//   empty_o    : occupancy is zero
//   fill_o     : current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module regex_rec_fifo
  import regex_collect_pkg::*;
#(
  parameter type rec_t = match_rec_t,
  parameter int  DEPTH = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  rec_t                   din_i,
  input  logic                   pop_i,
  output rec_t                   dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] fill_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Pointers carry one wrap bit above the address so full and empty differ.
  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  rec_t        mem_q [DEPTH];
  logic        push_ok;
  logic        pop_ok;

  always_comb begin
    fill_o  = wr_q - rd_q;
    full_o  = (fill_o == FULL_CNT);
    empty_o = (fill_o == '0);
    pop_ok  = pop_i & ~empty_o;
    // When full, the slot being written is the one the pop releases.
    push_ok = push_i & (~full_o | pop_ok);
    wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
    rd_d    = pop_ok  ? rd_q + 1'b1 : rd_q;
    dout_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/regex_match_collector.sv
// -----------------------------------------------------------------------------
// regex_match_collector
// Sink end of the regex pipeline. Every valid beat advances a wrapping beat
// index; beats with a nonzero signal word (while en is high) are queued as
// {idx, sig} records and drained through a valid/ready read port.
// Optional build macro: REGEX_MATCH_COLLECT_DEDUP_EN -- suppress a record whose
// sig repeats the previous qualifying beat's sig at the immediately following
// index, so a run of identical matches reports only its first beat.
// Ports:
//   clk, rst           : clock, asynchronous active-high reset
//   start              : pulse; clears beat index, overflow, drop_cnt (not FIFO)
//   en                 : collection enable (index advances regardless)
//   sig_valid, sig     : pipeline beat valid and signal word
//   rec_valid, rec_ready, rec_idx, rec_sig : FIFO head read port
//   overflow           : sticky, a record was dropped since start/reset
//   drop_cnt           : dropped record count, saturating
//   fill               : FIFO occupancy
// -----------------------------------------------------------------------------
module regex_match_collector
  import regex_collect_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF,
  parameter int IDX_W = IDX_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   en,
  input  logic                   sig_valid,
  input  logic [SIG_W-1:0]       sig,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [IDX_W-1:0]       rec_idx,
  output logic [SIG_W-1:0]       rec_sig,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic [$clog2(DEPTH):0] fill
);

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [SIG_W-1:0] sig;
  } rec_t;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] beat_idx;
  logic             hit;
  logic             push_req;
  logic             pop;
  logic             full;
  logic             empty;
  logic             drop;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] cnt_base;
  rec_t             push_rec;
  rec_t             head;

  // A beat coinciding with start belongs to the new stream as index 0.
  always_comb begin
    beat_idx = start ? '0 : idx_q;
    idx_d    = idx_q;
    if (sig_valid) begin
      idx_d = beat_idx + 1'b1;
    end else if (start) begin
      idx_d = '0;
    end
    // sig is only meaningful on valid beats, so it is gated by sig_valid first.
    hit = sig_valid && en && (sig != '0);
    push_rec.idx = beat_idx;
    push_rec.sig = sig;
  end

`ifdef REGEX_MATCH_COLLECT_DEDUP_EN
  logic             run_vld_q, run_vld_d;
  logic [SIG_W-1:0] run_sig_q, run_sig_d;
  logic [IDX_W-1:0] run_idx_q, run_idx_d;
  logic [IDX_W-1:0] run_next;
  logic             dup;

  // The tracker follows every qualifying beat, suppressed or not, so a long
  // run keeps matching; any valid non-qualifying beat ends the run.
  always_comb begin
    run_next  = run_idx_q + 1'b1;
    dup       = hit && run_vld_q && !start &&
                (sig == run_sig_q) && (beat_idx == run_next);
    run_vld_d = start ? 1'b0 : run_vld_q;
    run_sig_d = run_sig_q;
    run_idx_d = run_idx_q;
    if (hit) begin
      run_vld_d = 1'b1;
      run_sig_d = sig;
      run_idx_d = beat_idx;
    end else if (sig_valid) begin
      run_vld_d = 1'b0;
    end
    push_req = hit & ~dup;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_vld_q <= 1'b0;
    end else begin
      run_vld_q <= run_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    run_sig_q <= run_sig_d;
    run_idx_q <= run_idx_d;
  end
`else
  always_comb begin
    push_req = hit;
  end
`endif

  // A push into a full FIFO is only lost when no pop frees a slot this cycle.
  always_comb begin
    pop        = ~empty & rec_ready;
    drop       = push_req & full & ~pop;
    overflow_d = (start ? 1'b0 : overflow_q) | drop;
    cnt_base   = start ? '0 : drop_cnt_q;
    drop_cnt_d = (drop && (cnt_base != '1)) ? cnt_base + 1'b1 : cnt_base;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  regex_rec_fifo #(
    .rec_t (rec_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_req),
    .din_i   (push_rec),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .fill_o  (fill)
  );

  assign rec_valid = ~empty;
  assign rec_idx   = head.idx;
  assign rec_sig   = head.sig;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
